// File: rtl/instr_loader.sv
// Serial program loader: frames a byte stream (count, then HI/LO byte pairs)
// into 14-bit instruction-memory writes while holding the CPU fetch path.
module instr_loader #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               busy,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [ADDR_W-1:0]  word_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t             state_r, state_next;
  logic [7:0]         n_r, n_next;
  // Separate 8-bit tally so the N comparison is independent of ADDR_W.
  logic [7:0]         written_r, written_next;
  logic [5:0]         hi_r, hi_next;
  logic [ADDR_W-1:0]  addr_r, addr_next;
  logic [ADDR_W-1:0]  word_count_r, word_count_next;
  logic               byte_ready_r, byte_ready_next;
  logic               mem_we_r, mem_we_next;
  logic [ADDR_W-1:0]  mem_addr_r, mem_addr_next;
  logic [INSTR_W-1:0] mem_wdata_r, mem_wdata_next;
  logic               busy_r, busy_next;
  logic               done_r, done_next;
  logic               error_r, error_next;
  logic               accept_s;

  assign accept_s = byte_valid & byte_ready_r;

  // Next-state, datapath and output decode; all outputs are registered from these.
  always_comb begin
    state_next      = state_r;
    n_next          = n_r;
    written_next    = written_r;
    hi_next         = hi_r;
    addr_next       = addr_r;
    word_count_next = word_count_r;
    mem_we_next     = 1'b0;
    mem_addr_next   = mem_addr_r;
    mem_wdata_next  = mem_wdata_r;
    done_next       = 1'b0;
    error_next      = error_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          state_next      = LEN;
          error_next      = 1'b0;
          word_count_next = {ADDR_W{1'b0}};
          addr_next       = {ADDR_W{1'b0}};
          written_next    = 8'd0;
        end else begin
          state_next = IDLE;
        end
      end
      LEN: begin
        if (accept_s) begin
          n_next = byte_data;
          if (byte_data == 8'd0) begin
            state_next = ERR;
            error_next = 1'b1;
          end else begin
            state_next = HI;
          end
        end else begin
          state_next = LEN;
        end
      end
      HI: begin
        if (accept_s) begin
          hi_next = byte_data[5:0];
          if (byte_data[7:6] != 2'b00) begin
            state_next = ERR;
            error_next = 1'b1;
          end else begin
            state_next = LO;
          end
        end else begin
          state_next = HI;
        end
      end
      LO: begin
        if (accept_s) begin
          state_next     = WRITE;
          mem_we_next    = 1'b1;
          mem_addr_next  = addr_r;
          mem_wdata_next = INSTR_W'({hi_r, byte_data});
        end else begin
          state_next = LO;
        end
      end
      WRITE: begin
        addr_next       = addr_r + ADDR_W'(1);
        word_count_next = word_count_r + ADDR_W'(1);
        written_next    = written_r + 8'd1;
        if ((written_r + 8'd1) == n_r) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          state_next = HI;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      ERR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    byte_ready_next = (state_next == LEN) || (state_next == HI) || (state_next == LO);
    busy_next       = (state_next != IDLE);
  end

  // State and registered-output update; reset aborts any load at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      n_r          <= 8'd0;
      written_r    <= 8'd0;
      hi_r         <= 6'd0;
      addr_r       <= {ADDR_W{1'b0}};
      word_count_r <= {ADDR_W{1'b0}};
      byte_ready_r <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {INSTR_W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r      <= state_next;
      n_r          <= n_next;
      written_r    <= written_next;
      hi_r         <= hi_next;
      addr_r       <= addr_next;
      word_count_r <= word_count_next;
      byte_ready_r <= byte_ready_next;
      mem_we_r     <= mem_we_next;
      mem_addr_r   <= mem_addr_next;
      mem_wdata_r  <= mem_wdata_next;
      busy_r       <= busy_next;
      done_r       <= done_next;
      error_r      <= error_next;
    end
  end

  assign byte_ready = byte_ready_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign busy       = busy_r;
  assign cpu_hold   = busy_r;
  assign done       = done_r;
  assign error      = error_r;
  assign word_count = word_count_r;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a frame-level model queues expected writes,
// a negedge monitor pops and compares them as the DUT strobes mem_we.
module tb_instr_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [13:0] mem_wdata;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [7:0]  word_count;

  int checks   = 0;
  int failures = 0;
  int busy_cyc = 0;
  int done_cnt = 0;
  int glob_cyc = 0;

  logic [7:0]  stream[$];
  logic [21:0] exp_q[$];
  logic [21:0] exp_e;

  instr_loader #(.ADDR_W(8), .INSTR_W(14)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) glob_cyc <= glob_cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      chk("cpu_hold_eq_busy", {31'd0, cpu_hold}, {31'd0, busy});
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write addr=%0h data=%0h", mem_addr, mem_wdata);
        end else begin
          exp_e = exp_q.pop_front();
          chk("write", {10'd0, mem_addr, mem_wdata}, {10'd0, exp_e});
        end
      end
    end
  end

  // Frame-level reference: what the stream means, not how the FSM walks it.
  task automatic model_load(output int consumed, output bit err, output int words, output int bcyc);
    int n;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] a;
    err = 1'b0; words = 0; consumed = 1;
    n = int'(stream[0]);
    if (n == 0) begin
      err = 1'b1; bcyc = 2;
      return;
    end
    for (int i = 0; i < n; i++) begin
      hi = stream[1 + 2 * i];
      consumed++;
      if (hi[7:6] != 2'b00) begin
        err = 1'b1; bcyc = 3 * i + 3;
        return;
      end
      lo = stream[2 + 2 * i];
      consumed++;
      a = 8'(i % 256);
      exp_q.push_back({a, hi[5:0], lo});
      words++;
    end
    bcyc = 3 * n + 2;
  endtask

  task automatic gen_stream(input int n);
    stream.delete();
    stream.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) == 0) stream.push_back(8'($urandom_range(64, 255)));
      else stream.push_back(8'($urandom_range(0, 63)));
      stream.push_back(8'($urandom_range(0, 255)));
    end
  endtask

  // Offer one byte until accepted; mode 0 always valid, 1 one-of-three, 2 random.
  task automatic send_byte(input logic [7:0] b, input int mode, input int spur);
    bit acc;
    acc = 1'b0;
    byte_data = b;
    for (int c = 0; c < 200 && !acc; c++) begin
      case (mode)
        0: byte_valid = 1'b1;
        1: byte_valid = (glob_cyc % 3 == 0);
        default: byte_valid = ($urandom_range(0, 1) == 1);
      endcase
      start = (spur != 0) && busy && ($urandom_range(0, 2) == 0);
      acc = byte_valid && byte_ready;
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL byte_accept_timeout byte=%0h accepted=0 required=1", b);
    end
  endtask

  task automatic run_load(input int mode, input int spur, input string tag);
    int consumed, words, bcyc;
    bit err;
    model_load(consumed, err, words, bcyc);
    busy_cyc = 0;
    done_cnt = 0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_error_cleared"}, {31'd0, error}, 32'd0);
    chk({tag, "_busy_in_len"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < consumed; i++) send_byte(stream[i], mode, spur);
    byte_valid = 1'b0;
    for (int k = 0; k < 40 && busy; k++) @(negedge clk);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_writes_left"}, exp_q.size(), 32'd0);
    exp_q.delete();
    chk({tag, "_error"}, {31'd0, error}, {31'd0, err});
    chk({tag, "_word_count"}, {24'd0, word_count}, words);
    chk({tag, "_done_pulses"}, done_cnt, err ? 32'd0 : 32'd1);
    if (mode == 0) chk({tag, "_busy_cycles"}, busy_cyc, bcyc);
    repeat (2) @(negedge clk);
    chk({tag, "_word_count_hold"}, {24'd0, word_count}, words);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time_limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
    #12;
    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {18'd0, mem_wdata}, 32'd0);
    chk("rst_word_count", {24'd0, word_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    byte_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("quiet_before_start", {30'd0, busy, byte_ready}, 32'd0);
    end
    byte_valid = 1'b0;

    stream = '{8'h02, 8'h3F, 8'hFF, 8'h00, 8'h5A};
    run_load(0, 0, "two_words");
    stream = '{8'h00};
    run_load(0, 0, "zero_len");
    stream = '{8'h01, 8'h40};
    run_load(0, 0, "bad_hi");
    stream = '{8'h03, 8'h01, 8'h23, 8'h2A, 8'hBC, 8'h15, 8'h77};
    run_load(1, 0, "valid_1of3");
    stream = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h05, 8'h66};
    run_load(0, 1, "start_in_hi");

    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 11) == 0) gen_stream(0);
      else gen_stream(int'($urandom_range(1, 8)));
      run_load((t % 2 == 0) ? 0 : 2, int'($urandom_range(0, 1)), "random");
    end

    gen_stream(255);
    for (int i = 0; i < 255; i++) stream[1 + 2 * i] = {2'b00, stream[1 + 2 * i][5:0]};
    run_load(0, 0, "max_len");

    // Abort a 4-word load after the second word's write has completed.
    busy_cyc = 0;
    exp_q.push_back({8'd0, 6'h12, 8'h34});
    exp_q.push_back({8'd1, 6'h05, 8'h67});
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h04, 0, 0);
    send_byte(8'h12, 0, 0);
    send_byte(8'h34, 0, 0);
    send_byte(8'h05, 0, 0);
    send_byte(8'h67, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_outputs", {21'd0, byte_ready, mem_we, busy, cpu_hold, done, error, word_count},
        32'd0);
    chk("abort_addr_data", {10'd0, mem_addr, mem_wdata}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    byte_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_quiet", {29'd0, busy, byte_ready, mem_we}, 32'd0);
    end
    byte_valid = 1'b0;
    chk("abort_writes_left", exp_q.size(), 32'd0);
    exp_q.delete();

    stream = '{8'h01, 8'h2C, 8'hD1};
    run_load(0, 0, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
